// File: rtl/log_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : log_capture_ctrl_if
// Brief   : Register-file / DSP / BRAM signal bundle for the log capture ctrl
// Revision: 1.0
// ============================================================================
interface log_capture_ctrl_if #(
    parameter int N_ADDR = 10,
    parameter int DATA_W = 22,
    parameter int DEC_W  = 4
);
    logic              i_run_log;
    logic              i_read_log;
    logic [N_ADDR-1:0] i_addr_log_to_mem;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic [DEC_W-1:0]  i_decim;
    logic [DATA_W-1:0] i_mem_dout;
    logic [N_ADDR-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_din;
    logic              o_mem_we;
    logic              o_mem_regce;
    logic [DATA_W-1:0] o_data_log;
    logic              o_rd_valid;
    logic              o_mem_full;
    logic              o_busy;

    modport slave (
        input  i_run_log, i_read_log, i_addr_log_to_mem, i_data, i_data_valid,
               i_decim, i_mem_dout,
        output o_mem_addr, o_mem_din, o_mem_we, o_mem_regce, o_data_log,
               o_rd_valid, o_mem_full, o_busy
    );

    modport master (
        output i_run_log, i_read_log, i_addr_log_to_mem, i_data, i_data_valid,
               i_decim, i_mem_dout,
        input  o_mem_addr, o_mem_din, o_mem_we, o_mem_regce, o_data_log,
               o_rd_valid, o_mem_full, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/log_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : log_capture_ctrl
// Brief   : Decimating capture of {fir_Q,fir_I} into Memlog BRAM + read-back
// Revision: 1.0
// ============================================================================
module log_capture_ctrl #(
    parameter int N_ADDR = 10,
    parameter int DATA_W = 22,
    parameter int DEC_W  = 4,
    parameter int RD_LAT = 2
) (
    input  wire logic         clock,
    input  wire logic         i_reset,
    log_capture_ctrl_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(RD_LAT + 2);
    localparam logic [N_ADDR-1:0]  c_WPTR_LAST = {N_ADDR{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_CAP   = c_CNT_W'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOG  = 2'd1,
        S_FULL = 2'd2,
        S_READ = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_run_q;
    logic [N_ADDR-1:0]  r_wptr;
    logic [DEC_W-1:0]   r_dcnt, r_dec;
    logic [N_ADDR-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_din, r_data_log;
    logic               r_mem_we, r_mem_full, r_rd_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_run_start, w_start, w_wr, w_addr_chg;

    assign w_run_start = bus.i_run_log & ~r_run_q;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE, S_FULL: begin
                if (w_run_start) begin
                    w_state_nxt = S_LOG;
                    w_start     = 1'b1;
                end else if (bus.i_read_log) begin
                    w_state_nxt = S_READ;
                end
            end
            S_LOG: begin
                // A new run edge restarts the capture and drops this cycle's sample
                if (w_run_start) begin
                    w_start = 1'b1;
                end else if (bus.i_data_valid && (r_dcnt == '0)) begin
                    w_wr = 1'b1;
                    if (r_wptr == c_WPTR_LAST) w_state_nxt = S_FULL;
                end
            end
            S_READ: begin
                if (!bus.i_read_log) w_state_nxt = r_mem_full ? S_FULL : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_addr_chg = (w_state_nxt == S_READ) && (bus.i_addr_log_to_mem != r_mem_addr);

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_run_q    <= 1'b0;
            r_wptr     <= '0;
            r_dcnt     <= '0;
            r_dec      <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_full <= 1'b0;
            r_data_log <= '0;
            r_rd_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_run_q  <= bus.i_run_log;
            r_mem_we <= w_wr;
            if (w_start) begin
                r_wptr     <= '0;
                r_dcnt     <= '0;
                r_dec      <= bus.i_decim;
                r_mem_full <= 1'b0;
            end else begin
                // Sample 0 of each group of (dec+1) valid samples is stored
                if (r_state == S_LOG && bus.i_data_valid)
                    r_dcnt <= (r_dcnt == r_dec) ? '0 : r_dcnt + 1'b1;
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                if (r_state == S_FULL) r_mem_full <= 1'b1;
            end
            if (w_wr) begin
                r_mem_addr <= r_wptr;
                r_mem_din  <= bus.i_data;
            end else if (w_state_nxt == S_READ) begin
                r_mem_addr <= bus.i_addr_log_to_mem;
            end
            // Read-back: count cycles since the BRAM address settled, capture at RD_LAT
            if (r_state != S_READ || w_state_nxt != S_READ || w_addr_chg) begin
                r_cnt      <= '0;
                r_rd_valid <= 1'b0;
            end else if (r_cnt == c_CNT_CAP) begin
                r_data_log <= bus.i_mem_dout;
                r_rd_valid <= 1'b1;
                r_cnt      <= r_cnt + 1'b1;
            end else if (r_cnt < c_CNT_CAP) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_din   = r_mem_din;
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_regce = (r_state == S_READ);
    assign bus.o_data_log  = r_data_log;
    assign bus.o_rd_valid  = r_rd_valid;
    assign bus.o_mem_full  = r_mem_full;
    assign bus.o_busy      = (r_state == S_LOG);
endmodule
`default_nettype wire

// File: tb/tb_log_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_log_capture_ctrl
// Brief   : Directed self-checking bench for log_capture_ctrl with BRAM model
// Revision: 1.0
// ============================================================================
module tb_log_capture_ctrl;
    localparam int N_ADDR = 4;
    localparam int DATA_W = 22;
    localparam int DEC_W  = 4;
    localparam int RD_LAT = 2;

    logic clock = 1'b0;
    logic i_reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_we;

    always #5 clock = ~clock;

    log_capture_ctrl_if #(.N_ADDR(N_ADDR), .DATA_W(DATA_W), .DEC_W(DEC_W)) bus ();

    log_capture_ctrl #(
        .N_ADDR(N_ADDR), .DATA_W(DATA_W), .DEC_W(DEC_W), .RD_LAT(RD_LAT)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    // BRAM with output register: two-cycle read latency, regce gates the output stage
    logic [DATA_W-1:0] mem [2**N_ADDR];
    logic [DATA_W-1:0] mem_lat;
    initial begin
        for (int i = 0; i < 2**N_ADDR; i++) mem[i] = '0;
        mem_lat        = '0;
        bus.i_mem_dout = '0;
    end
    always @(posedge clock) begin
        if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_din;
        mem_lat <= mem[bus.o_mem_addr];
        if (bus.o_mem_regce) bus.i_mem_dout <= mem_lat;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        i_reset               = 1'b1;
        bus.i_run_log         = 1'b0;
        bus.i_read_log        = 1'b0;
        bus.i_addr_log_to_mem = '0;
        bus.i_data            = '0;
        bus.i_data_valid      = 1'b0;
        bus.i_decim           = '0;
        repeat (2) step();
        check("rst_flags", {bus.o_mem_we, bus.o_mem_regce, bus.o_rd_valid, bus.o_mem_full, bus.o_busy}, 0);
        check("rst_addr", bus.o_mem_addr, 0);
        check("rst_din", bus.o_mem_din, 0);
        check("rst_dlog", bus.o_data_log, 0);

        // Reset asserted mid-capture
        i_reset = 1'b0;
        step();
        bus.i_run_log = 1'b1;
        step();
        check("t1_busy", bus.o_busy, 1);
        for (int k = 0; k < 3; k++) begin
            bus.i_data_valid = 1'b1;
            bus.i_data       = DATA_W'(50 + k);
            step();
        end
        check("t1_we_before", {bus.o_mem_we, bus.o_mem_addr}, {1'b1, N_ADDR'(2)});
        #2;
        i_reset          = 1'b1;
        bus.i_run_log    = 1'b0;
        bus.i_data_valid = 1'b0;
        #1;
        check("t1_async_flags", {bus.o_mem_we, bus.o_busy, bus.o_mem_full, bus.o_rd_valid}, 0);
        check("t1_async_addr", bus.o_mem_addr, 0);
        check("t1_async_din", bus.o_mem_din, 0);
        step();
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1_no_we_after", {bus.o_mem_we, bus.o_busy}, 0);
        end

        // Gapped valid, no decimation
        bus.i_run_log = 1'b1;
        bus.i_decim   = '0;
        step();
        for (int k = 0; k < 16; k++) begin
            bus.i_data_valid = 1'b1;
            bus.i_data       = DATA_W'(100 + k);
            step();
            check("t4_wr", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din},
                  {1'b1, N_ADDR'(k), DATA_W'(100 + k)});
            bus.i_data_valid = 1'b0;
            step();
            check("t4_gap1", bus.o_mem_we, 0);
            step();
            check("t4_gap2", bus.o_mem_we, 0);
        end
        check("t4_full", bus.o_mem_full, 1);

        // Decimation by 3; a decim change mid-capture must not matter
        bus.i_run_log = 1'b0;
        step();
        bus.i_run_log = 1'b1;
        bus.i_decim   = DEC_W'(2);
        step();
        n_we = 0;
        for (int k = 0; k < 48; k++) begin
            bus.i_data_valid = 1'b1;
            bus.i_data       = DATA_W'(k);
            if (k == 20) bus.i_decim = '0;
            step();
            if (bus.o_mem_we) n_we++;
        end
        bus.i_data_valid = 1'b0;
        check("t3_we_count", n_we, 16);
        check("t3_full", bus.o_mem_full, 1);
        for (int i = 0; i < 16; i++) check("t3_word", mem[i], 3 * i);

        // Run edge during LOG restarts at address 0; read_log during LOG is ignored
        bus.i_run_log = 1'b0;
        step();
        bus.i_run_log = 1'b1;
        bus.i_decim   = '0;
        step();
        for (int k = 0; k < 5; k++) begin
            bus.i_data_valid = 1'b1;
            bus.i_data       = DATA_W'(200 + k);
            step();
            check("t6a_wr", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din},
                  {1'b1, N_ADDR'(k), DATA_W'(200 + k)});
        end
        bus.i_run_log = 1'b0;
        bus.i_data    = DATA_W'(205);
        step();
        check("t6a_wr5", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din}, {1'b1, N_ADDR'(5), DATA_W'(205)});
        bus.i_run_log = 1'b1;
        bus.i_data    = DATA_W'(206);
        step();
        check("t6a_drop", {bus.o_mem_we, bus.o_busy}, {1'b0, 1'b1});
        bus.i_data = DATA_W'(300);
        step();
        check("t6a_restart", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din}, {1'b1, N_ADDR'(0), DATA_W'(300)});
        bus.i_read_log = 1'b1;
        for (int k = 1; k < 16; k++) begin
            bus.i_data = DATA_W'(300 + k);
            step();
            check("t6c_wr", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din},
                  {1'b1, N_ADDR'(k), DATA_W'(300 + k)});
        end
        check("t6c_busy_fall", bus.o_busy, 0);
        check("t6c_full_lag", bus.o_mem_full, 0);
        bus.i_data_valid = 1'b0;
        step();
        check("t6c_full", {bus.o_mem_full, bus.o_mem_regce}, {1'b1, 1'b1});

        // Run edge during READ writes nothing
        bus.i_run_log = 1'b0;
        step();
        bus.i_run_log = 1'b1;
        step();
        step();
        check("t6b_quiet", {bus.o_mem_we, bus.o_busy, bus.o_mem_regce}, {1'b0, 1'b0, 1'b1});
        check("t6b_mem0", mem[0], 300);
        bus.i_read_log = 1'b0;
        step();
        check("t6b_exit", {bus.o_mem_regce, bus.o_mem_full}, {1'b0, 1'b1});

        // Full capture of a 0..15 counter from FULL
        bus.i_run_log = 1'b0;
        step();
        bus.i_run_log = 1'b1;
        step();
        check("t2_start", {bus.o_busy, bus.o_mem_full}, {1'b1, 1'b0});
        for (int k = 0; k < 16; k++) begin
            bus.i_data_valid = 1'b1;
            bus.i_data       = DATA_W'(k);
            step();
            check("t2_wr", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din},
                  {1'b1, N_ADDR'(k), DATA_W'(k)});
        end
        check("t2_after_last", {bus.o_busy, bus.o_mem_full}, 0);
        bus.i_data_valid = 1'b0;
        step();
        check("t2_full", {bus.o_mem_full, bus.o_mem_we}, {1'b1, 1'b0});

        // Read-back with latency RD_LAT+1 and address change
        bus.i_read_log        = 1'b1;
        bus.i_addr_log_to_mem = N_ADDR'(5);
        step();
        check("t5_rv_c0", bus.o_rd_valid, 0);
        step();
        step();
        check("t5_rv_c2", bus.o_rd_valid, 0);
        step();
        check("t5_rv_c3", bus.o_rd_valid, 1);
        check("t5_data5", bus.o_data_log, 5);
        bus.i_addr_log_to_mem = N_ADDR'(9);
        step();
        check("t5_rv_clr", bus.o_rd_valid, 0);
        check("t5_addr9", bus.o_mem_addr, 9);
        step();
        step();
        check("t5_rv_wait", bus.o_rd_valid, 0);
        step();
        check("t5_rv_9", bus.o_rd_valid, 1);
        check("t5_data9", bus.o_data_log, 9);
        bus.i_read_log = 1'b0;
        step();
        check("t5_exit", {bus.o_mem_regce, bus.o_mem_full}, {1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
